// File: rtl/stack_ctrl_if.sv
// Request/response channel between a stack client and stack_ctrl.
// The client holds req_valid until req_ready; done/err/rdata report completion.
interface stack_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_op;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, done, err, rdata
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, done, err, rdata
    );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO sequencer over an external up/down counter (sp) and a synchronous RAM.
// Latency accept->done: push 2, pop 4, error 1; req_ready only in IDLE, requests elsewhere are dropped.
module stack_ctrl #(
    parameter int WIDTH  = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    stack_ctrl_if.slave       req,
    input  logic [WIDTH-1:0]  sp,
    output logic              ctr_en,
    output logic              ctr_dir,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              full,
    output logic              empty,
    output logic [WIDTH:0]    occ
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP_INC,
        POP_RD,
        POP_CAP,
        RESP
    } state_t;

    localparam logic [WIDTH:0] OCC_MAX = {1'b1, {WIDTH{1'b0}}};

    state_t            state;
    logic [WIDTH:0]    occ_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic              err_q;
    logic              ctr_en_q;
    logic              ctr_dir_q;
    logic              mem_we_q;
    logic              mem_re_q;

    assign full          = (occ_q == OCC_MAX);
    assign empty         = (occ_q == '0);
    assign occ           = occ_q;
    assign mem_addr      = sp;
    assign mem_wdata     = wdata_q;
    assign mem_we        = mem_we_q;
    assign mem_re        = mem_re_q;
    assign ctr_en        = ctr_en_q;
    assign ctr_dir       = ctr_dir_q;
    assign req.req_ready = (state == IDLE);
    assign req.done      = done_q;
    assign req.err       = err_q;
    assign req.rdata     = rdata_q;

    // Strobes default low each cycle and are raised on the transition into
    // the state that owns them, so they are high exactly while in that state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            occ_q     <= '0;
            rdata_q   <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ctr_en_q  <= 1'b0;
            ctr_dir_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
        end else begin
            ctr_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        if (req.req_op ? full : empty) begin
                            state  <= RESP;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else if (req.req_op) begin
                            state     <= PUSH;
                            wdata_q   <= req.req_data;
                            mem_we_q  <= 1'b1;
                            ctr_en_q  <= 1'b1;
                            ctr_dir_q <= 1'b0;
                        end else begin
                            state     <= POP_INC;
                            ctr_en_q  <= 1'b1;
                            ctr_dir_q <= 1'b1;
                        end
                    end
                end
                PUSH: begin
                    occ_q  <= occ_q + 1'b1;
                    state  <= RESP;
                    done_q <= 1'b1;
                end
                POP_INC: begin
                    // sp has moved to the top entry by the time POP_RD reads it
                    occ_q    <= occ_q - 1'b1;
                    state    <= POP_RD;
                    mem_re_q <= 1'b1;
                end
                POP_RD: begin
                    state <= POP_CAP;
                end
                POP_CAP: begin
                    rdata_q <= mem_rdata;
                    state   <= RESP;
                    done_q  <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
